// File: rtl/halving_counter_pkg.sv
// Shared types for the fixed-point halving/doubling counter.
// Imported by the step datapath and the sequencing top level.
package halving_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_HALVE  = 1'b0,
        MODE_DOUBLE = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        CAUSE_END  = 2'd0,
        CAUSE_SAT  = 2'd1,
        CAUSE_ZERO = 2'd2
    } cause_e;

endpackage

// File: rtl/halving_counter_if.sv
// Start / step / completion bundle of the halving counter.
// master drives requests and accepts steps; slave is the engine.
interface halving_counter_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] start_value;
    logic             start_mode;
    logic             step_valid;
    logic             step_ready;
    logic [WIDTH-1:0] step_value;
    logic [CNT_W-1:0] step_count;
    logic             done;
    logic [CNT_W-1:0] done_count;
    logic [1:0]       done_cause;

    modport master (
        output start_valid, start_value, start_mode, step_ready,
        input  start_ready, step_valid, step_value, step_count,
        input  done, done_count, done_cause
    );

    modport slave (
        input  start_valid, start_value, start_mode, step_ready,
        output start_ready, step_valid, step_value, step_count,
        output done, done_count, done_cause
    );
endinterface

// File: rtl/halving_step.sv
// Next-value function: shift right (halve) or left (double) and
// flag when the sequence ends instead of producing a usable value.
module halving_step
    import halving_counter_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] value_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] next_o,
    output logic             term_o
);

    always_comb begin
        next_o = value_i;
        term_o = 1'b1;
        unique case (mode_i)
            MODE_HALVE: begin
                next_o = value_i >> 1;
                term_o = (value_i >> 1) == '0;
            end
            MODE_DOUBLE: begin
                next_o = value_i << 1;
                term_o = value_i[WIDTH-1];
            end
            default: begin
                next_o = value_i;
                term_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/halving_counter.sv
// Sequencer for the halving counter: accepts a start value, streams each
// halved/doubled value with a 1-based count, then pulses done with a cause.
module halving_counter
    import halving_counter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input logic               clk,
    input logic               rst,
    halving_counter_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CNT_W-1:0] count_q, count_d;
    mode_e            mode_q,  mode_d;
    cause_e           cause_q, cause_d;

    logic [WIDTH-1:0] step_in;
    mode_e            step_mode;
    logic [WIDTH-1:0] step_next;
    logic             step_term;

    // One step unit serves both the start check and the streaming path
    assign step_in   = (state_q == IDLE) ? bus.start_value : value_q;
    assign step_mode = (state_q == IDLE) ? mode_e'(bus.start_mode) : mode_q;

    halving_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .value_i (step_in),
        .mode_i  (step_mode),
        .next_o  (step_next),
        .term_o  (step_term)
    );

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        count_d = count_q;
        mode_d  = mode_q;
        cause_d = cause_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    mode_d  = mode_e'(bus.start_mode);
                    count_d = '0;
                    unique case (1'b1)
                        (bus.start_value == '0): begin
                            cause_d = CAUSE_ZERO;
                            state_d = DONE;
                        end
                        (bus.start_value != '0) && step_term: begin
                            cause_d = CAUSE_END;
                            state_d = DONE;
                        end
                        default: begin
                            value_d = step_next;
                            count_d = CNT_W'(1);
                            state_d = EMIT;
                        end
                    endcase
                end
            end
            EMIT: begin
                if (bus.step_ready) begin
                    unique case (1'b1)
                        step_term: begin
                            cause_d = CAUSE_END;
                            state_d = DONE;
                        end
                        !step_term && (count_q == '1): begin
                            cause_d = CAUSE_SAT;
                            state_d = DONE;
                        end
                        default: begin
                            value_d = step_next;
                            count_d = count_q + CNT_W'(1);
                        end
                    endcase
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            value_q <= '0;
            count_q <= '0;
            mode_q  <= MODE_HALVE;
            cause_q <= CAUSE_END;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            cause_q <= cause_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.step_valid  = (state_q == EMIT);
    assign bus.done        = (state_q == DONE);
    assign bus.step_value  = value_q;
    assign bus.step_count  = count_q;
    assign bus.done_count  = count_q;
    assign bus.done_cause  = cause_q;

endmodule

// File: tb/tb_halving_counter.sv
// Bench for halving_counter: two 8-bit engines (7-bit and 2-bit counters)
// share one stimulus stream and are compared against an arithmetic model.
module tb_halving_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sv_i;
    logic [7:0] val_i;
    logic       mode_i;
    logic       rdy_i;

    halving_counter_if #(.WIDTH(8), .CNT_W(7)) bus_a ();
    halving_counter_if #(.WIDTH(8), .CNT_W(2)) bus_b ();

    assign bus_a.start_valid = sv_i;
    assign bus_a.start_value = val_i;
    assign bus_a.start_mode  = mode_i;
    assign bus_a.step_ready  = rdy_i;
    assign bus_b.start_valid = sv_i;
    assign bus_b.start_value = val_i;
    assign bus_b.start_mode  = mode_i;
    assign bus_b.step_ready  = rdy_i;

    halving_counter #(.WIDTH(8), .CNT_W(7)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    halving_counter #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int checks = 0;
    int fails  = 0;

    int exp_a[128];
    int exp_b[128];
    int len_a, len_b, cause_a, cause_b;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected step list from plain arithmetic: /2 or *2 until the result
    // would be zero or overflow 8 bits, capped at maxc steps.
    task automatic build(input int v, input bit m, input int maxc,
                         input bit sel);
        int cur, nxt, len, cause;
        bit ok;
        cur = v;
        len = 0;
        cause = 0;
        if (v == 0) cause = 2;
        else begin
            while (1) begin
                if (!m) begin
                    nxt = cur / 2;
                    ok  = (nxt != 0);
                end else begin
                    nxt = cur * 2;
                    ok  = (nxt < 256);
                end
                if (!ok) break;
                if (len == maxc) begin
                    cause = 1;
                    break;
                end
                cur = nxt;
                if (sel) exp_b[len] = cur;
                else     exp_a[len] = cur;
                len++;
            end
        end
        if (sel) begin
            len_b = len;
            cause_b = cause;
        end else begin
            len_a = len;
            cause_a = cause;
        end
    endtask

    task automatic run(input int v, input bit m, input bit rnd,
                       input int stall_at);
        int ia, ib, stall, cyc;
        bit fa, fb;
        build(v, m, 127, 1'b0);
        build(v, m, 3, 1'b1);
        @(negedge clk);
        chk("start_ready_a", bus_a.start_ready, 1);
        chk("start_ready_b", bus_b.start_ready, 1);
        sv_i   = 1'b1;
        val_i  = v[7:0];
        mode_i = m;
        rdy_i  = 1'b0;
        @(negedge clk);
        sv_i   = 1'b0;
        val_i  = 8'($urandom);
        mode_i = 1'($urandom);
        ia = 0; ib = 0; fa = 0; fb = 0; stall = 0; cyc = 0;
        while (!(fa && fb) && cyc < 200) begin
            if (stall_at > 0 && !fa && ia + 1 == stall_at && stall < 5) begin
                rdy_i = 1'b0;
                stall++;
            end else begin
                rdy_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (!fa) begin
                if (ia < len_a) begin
                    chk("a_valid", bus_a.step_valid, 1);
                    chk("a_value", bus_a.step_value, exp_a[ia]);
                    chk("a_count", bus_a.step_count, ia + 1);
                    chk("a_nodone", bus_a.done, 0);
                    chk("a_busy", bus_a.start_ready, 0);
                    if (rdy_i) ia++;
                end else begin
                    chk("a_done", bus_a.done, 1);
                    chk("a_done_count", bus_a.done_count, len_a);
                    chk("a_done_cause", bus_a.done_cause, cause_a);
                    chk("a_done_novalid", bus_a.step_valid, 0);
                    fa = 1;
                end
            end
            if (!fb) begin
                if (ib < len_b) begin
                    chk("b_valid", bus_b.step_valid, 1);
                    chk("b_value", bus_b.step_value, exp_b[ib]);
                    chk("b_count", bus_b.step_count, ib + 1);
                    chk("b_nodone", bus_b.done, 0);
                    if (rdy_i) ib++;
                end else begin
                    chk("b_done", bus_b.done, 1);
                    chk("b_done_count", bus_b.done_count, len_b);
                    chk("b_done_cause", bus_b.done_cause, cause_b);
                    fb = 1;
                end
            end else begin
                chk("b_idle_ready", bus_b.start_ready, 1);
                chk("b_idle_valid", bus_b.step_valid, 0);
                chk("b_idle_done", bus_b.done, 0);
            end
            @(negedge clk);
            cyc++;
        end
        chk("run_in_budget", cyc < 200, 1);
        chk("a_back_idle", bus_a.start_ready, 1);
        chk("a_done_once", bus_a.done, 0);
        chk("b_back_idle", bus_b.start_ready, 1);
    endtask

    initial begin
        rst    = 1'b1;
        sv_i   = 1'b0;
        val_i  = '0;
        mode_i = 1'b0;
        rdy_i  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_start_ready", bus_a.start_ready, 1);
        chk("rst_step_valid", bus_a.step_valid, 0);
        chk("rst_done", bus_a.done, 0);
        chk("rst_step_value", bus_a.step_value, 0);
        chk("rst_step_count", bus_a.step_count, 0);
        chk("rst_done_count", bus_a.done_count, 0);
        chk("rst_done_cause", bus_a.done_cause, 0);

        run(8'h80, 1'b0, 1'b0, 0);
        run(8'h01, 1'b1, 1'b0, 0);
        run(8'hC0, 1'b1, 1'b0, 0);
        run(0, 1'b0, 1'b0, 0);
        run(0, 1'b1, 1'b0, 0);
        run(1, 1'b0, 1'b0, 0);
        run(8'h80, 1'b0, 1'b0, 3);

        // Abort a HALVE run with reset while step 4 is presented
        @(negedge clk);
        sv_i   = 1'b1;
        val_i  = 8'h80;
        mode_i = 1'b0;
        @(negedge clk);
        sv_i  = 1'b0;
        rdy_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_count", bus_a.step_count, 4);
        chk("pre_rst_value", bus_a.step_value, 8'h08);
        rst  = 1'b1;
        sv_i = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        sv_i  = 1'b0;
        rdy_i = 1'b0;
        chk("abort_valid", bus_a.step_valid, 0);
        chk("abort_ready", bus_a.start_ready, 1);
        chk("abort_done", bus_a.done, 0);
        chk("abort_value", bus_a.step_value, 0);
        chk("abort_count", bus_a.step_count, 0);
        chk("abort_cause", bus_a.done_cause, 0);
        chk("abort_b_ready", bus_b.start_ready, 1);
        chk("abort_b_count", bus_b.done_count, 0);
        @(negedge clk);
        chk("abort_no_done", bus_a.done, 0);
        run(8'h04, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            int v;
            int sel;
            sel = $urandom_range(0, 7);
            if (sel == 0)      v = 0;
            else if (sel == 1) v = 1 << $urandom_range(0, 7);
            else               v = $urandom_range(0, 255);
            run(v, 1'($urandom_range(0, 1)), 1'b1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/halving_counter.md
# halving_counter

Parametrised, synthesizable successor to the real-valued halving counter. Accepts an unsigned WIDTH-bit start value, then repeatedly halves it (logical shift right) or doubles it (logical shift left). Each intermediate value is emitted on a valid/ready step stream with a 1-based step count. A completion pulse reports the final count and the cause of termination. The block is the fixed-point test and characterisation engine for precision-limit experiments, driven by a bench or a host sequencer.

## Interface
- WIDTH, 64, value width in bits, ≥2
- CNT_W, 7, step counter width, ≥1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  start request
- start_ready  out  1  high only in IDLE
- start_value  in  WIDTH  initial value, sampled on start handshake only
- start_mode  in  1  0 = HALVE, 1 = DOUBLE, sampled on start handshake only
- step_valid  out  1  step_value/step_count valid
- step_ready  in  1  consumer accepts step
- step_value  out  WIDTH  current value
- step_count  out  CNT_W  index of this step, 1-based
- done  out  1  one-cycle completion pulse
- done_count  out  CNT_W  number of steps emitted, valid with done
- done_cause  out  2  0 END, 1 SAT, 2 ZERO, valid with done

## Operation
- States:
  - IDLE: start_ready=1.
  - EMIT: step_valid=1.
  - DONE: done=1 for exactly one cycle.
- Next-value function f(v):
  - HALVE: result v>>1. Terminates when v>>1 == 0.
  - DOUBLE: result v<<1. Terminates when v[WIDTH-1]==1, i.e. the shift would lose the MSB.
- IDLE, on start handshake:
  - start_value==0: go to DONE with cause ZERO, count 0.
  - f(start_value) terminates: go to DONE with cause END, count 0.
  - Otherwise: value←f(start_value), count←1, go to EMIT.
- EMIT, on step handshake:
  - f(value) terminates: go to DONE with cause END. Count is unchanged.
  - Else if count == 2^CNT_W−1: go to DONE with cause SAT.
  - Otherwise: value←f(value), count←count+1, stay in EMIT.
- DONE: go to IDLE unconditionally. done_count=count, done_cause as latched.
- Backpressure: while step_valid && !step_ready, step_value and step_count hold stable.
- done is never asserted in the same cycle as step_valid or start_ready.
- Reset:
  - While rst is high, start_valid and step_ready are ignored.
  - The next state is IDLE, and value, count and cause registers are cleared.
  - Asserting rst mid-EMIT or in DONE aborts the run with no done pulse.
- Reset values after the rst cycle:
  - start_ready=1, step_valid=0, done=0.
  - step_value=0, step_count=0, done_count=0, done_cause=0.

## Timing
- Start accepted at edge N: step_valid high from cycle N+1, or done high in cycle N+1 for ZERO/END-at-start.
- Step k accepted at edge M: step k+1 is valid in cycle M+1. Full-throughput streaming is 1 step/cycle with step_ready held high.
- Final step accepted at edge M: done high in cycle M+1, start_ready high in cycle M+2.
- Minimum start-to-start spacing is 2 cycles (ZERO case).
- HALVE from 2^(WIDTH−1) emits WIDTH−1 steps when CNT_W permits.
- Outputs are registered or state-decoded only. There is no combinational path from step_ready or start_valid to any output.

## Structure
- Package halving_counter_pkg holds:
  - state_e {IDLE, EMIT, DONE}
  - mode_e {MODE_HALVE=0, MODE_DOUBLE=1}
  - cause_e {CAUSE_END=0, CAUSE_SAT=1, CAUSE_ZERO=2}
- Sub-module halving_step: combinational, parametrised by WIDTH; takes value and mode, returns next value and a terminate flag. It is instantiated once and shared by the IDLE and EMIT paths.
- Top level holds the FSM, the value/count/mode/cause registers and the handshake logic.

## Test plan
- WIDTH=8, HALVE, start 0x80, step_ready=1 → steps 0x40,0x20,0x10,0x08,0x04,0x02,0x01 with counts 1..7 on consecutive cycles; then done, done_count=7, cause END.
- WIDTH=8, DOUBLE, start 0x01 → steps 0x02..0x80 with counts 1..7; then done, count 7, cause END. Start 0xC0 → done next cycle, count 0, END.
- Start 0 (either mode) → no step_valid, done in cycle N+1, count 0, cause ZERO. HALVE start 1 → done, count 0, END.
- HALVE 0x80, step_ready low for 5 cycles while step 3 (0x10) is presented → value 0x10 and count 3 held stable; sequence resumes unchanged; done_count=7.
- CNT_W=2, HALVE 0x80 → steps 0x40,0x20,0x10 with counts 1..3; then done, count 3, cause SAT.
- rst pulsed for 1 cycle during step 4 of a HALVE 0x80 run → next cycle step_valid=0, start_ready=1, no done pulse. A new start 0x04 then yields 0x02, 0x01, done count 2.
